// File: rtl/sig_edge_monitor.sv
// sig_edge_monitor: synchronizes and debounces an asynchronous strobe/status
// line, emits registered rise/fall pulses, counts rising edges in a saturating
// counter and exposes that count to software through a req/ack snapshot.
module sig_edge_monitor #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sig_in,
  output logic                 sig_out,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  input  logic                 clr,
  input  logic                 snap_req,
  output logic                 snap_ack,
  output logic [CNT_WIDTH-1:0] snap_count,
  output logic                 overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_t;

  // Terminal value of the stable counter: reaching it with the input still
  // disagreeing means the new level has held for DEBOUNCE_CYCLES cycles.
  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_sync;
  logic [7:0]             stable_cnt;
  logic                   differ;
  logic                   toggle;
  logic [CNT_WIDTH-1:0]   event_cnt;
  snap_state_t            state;
  snap_state_t            state_nxt;

  assign s_sync = sync_p0[SYNC_STAGES-1];
  assign differ = (s_sync != sig_out);
  assign toggle = differ && (stable_cnt == DEB_LAST);

  // Synchronizer chain: shift the raw input towards s_sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig_in};
    end
  end

  // Debounce: count consecutive disagreeing cycles, flip the level once the
  // disagreement has persisted long enough, and flag the edge for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= 8'd0;
      sig_out    <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= toggle && !sig_out;
      fall_pulse <= toggle && sig_out;
      if (toggle) begin
        sig_out    <= ~sig_out;
        stable_cnt <= 8'd0;
      end else if (differ) begin
        stable_cnt <= stable_cnt + 8'd1;
      end else begin
        stable_cnt <= 8'd0;
      end
    end
  end

  // Event counter: clr has priority; a rise at all-ones holds the count and
  // latches the sticky overflow flag instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_cnt <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      event_cnt <= '0;
      overflow  <= 1'b0;
    end else if (rise_pulse) begin
      if (&event_cnt) begin
        overflow <= 1'b1;
      end else begin
        event_cnt <= event_cnt + CNT_ONE;
      end
    end
  end

  // Snapshot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Snapshot next-state: a request is honoured once, and a fresh request
  // needs snap_req to drop first.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (snap_req)  state_nxt = HOLD;
      HOLD:    if (!snap_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot register: captures the count (before any coincident increment)
  // on the IDLE->HOLD transition and stays frozen otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_count <= '0;
    end else if ((state == IDLE) && snap_req) begin
      snap_count <= event_cnt;
    end
  end

  assign snap_ack = (state == HOLD);

endmodule

// File: tb/tb_sig_edge_monitor.sv
// Bench for sig_edge_monitor: directed scenarios plus a randomized phase, all
// continuously compared against a behavioural model of the monitor.
module tb_sig_edge_monitor;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int CW   = 4;
  localparam longint CMAX = (longint'(1) << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sig_in = 1'b0;
  logic          clr = 1'b0;
  logic          snap_req = 1'b0;
  logic          sig_out, rise_pulse, fall_pulse, snap_ack, overflow;
  logic [CW-1:0] snap_count;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  sig_edge_monitor #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .sig_out(sig_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .clr(clr),
    .snap_req(snap_req), .snap_ack(snap_ack), .snap_count(snap_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: the input seen SYNC edges late must disagree with the
  // clean level for DEB consecutive edges before the level follows it.
  bit     m_dly[$];
  int     m_run;
  bit     m_out, m_rise, m_fall, m_ovf, m_hold;
  longint m_cnt, m_snap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dly = {};
      for (int i = 0; i < SYNC; i++) m_dly.push_back(1'b0);
      m_run = 0; m_out = 0; m_rise = 0; m_fall = 0;
      m_ovf = 0; m_hold = 0; m_cnt = 0; m_snap = 0;
    end else begin
      bit     seen, rise_prev;
      longint cnt_prev;
      seen = m_dly[0];
      rise_prev = m_rise;
      cnt_prev = m_cnt;
      m_rise = 0; m_fall = 0;
      if (seen != m_out) begin
        m_run++;
        if (m_run == DEB) begin
          m_out = seen; m_run = 0; m_rise = seen; m_fall = !seen;
        end
      end else begin
        m_run = 0;
      end
      if (clr) begin
        m_cnt = 0; m_ovf = 0;
      end else if (rise_prev) begin
        if (cnt_prev == CMAX) m_ovf = 1;
        else m_cnt = cnt_prev + 1;
      end
      if (!m_hold && snap_req) begin
        m_snap = cnt_prev; m_hold = 1;
      end else if (m_hold && !snap_req) begin
        m_hold = 0;
      end
      void'(m_dly.pop_front());
      m_dly.push_back(sig_in);
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_sig_out", 32'(sig_out), 32'(m_out));
      check("m_rise", 32'(rise_pulse), 32'(m_rise));
      check("m_fall", 32'(fall_pulse), 32'(m_fall));
      check("m_ack", 32'(snap_ack), 32'(m_hold));
      check("m_snap", 32'(snap_count), 32'(m_snap));
      check("m_ovf", 32'(overflow), 32'(m_ovf));
    end
  end

  // Edge counters observed from the DUT for the directed glitch checks.
  int n_rise = 0, n_fall = 0, n_high = 0;
  always @(negedge clk) begin
    if (rise_pulse) n_rise++;
    if (fall_pulse) n_fall++;
    if (sig_out) n_high++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    sig_in = 1'b1; tick(hi);
    sig_in = 1'b0; tick(lo);
  endtask

  task automatic snapshot(input string tag, input int exp_cnt);
    snap_req = 1'b1; tick(1);
    check({tag, "_ack1"}, 32'(snap_ack), 32'd1);
    check({tag, "_cnt"}, 32'(snap_count), 32'(exp_cnt));
    snap_req = 1'b0; tick(1);
    check({tag, "_ack0"}, 32'(snap_ack), 32'd0);
  endtask

  task automatic clear;
    clr = 1'b1; tick(1); clr = 1'b0;
  endtask

  task automatic wait_rise(input string tag);
    int k;
    k = 0;
    while (!rise_pulse && k < 20) begin tick(1); k++; end
    check({tag, "_seen"}, 32'(rise_pulse), 32'd1);
  endtask

  initial begin
    // 1. Reset state and first-rise latency.
    sig_in = 1'b1;
    tick(3);
    check("rst_sig_out", 32'(sig_out), 32'd0);
    check("rst_ack", 32'(snap_ack), 32'd0);
    check("rst_snap", 32'(snap_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_rise", 32'(rise_pulse), 32'd0);
    cmp_en = 1'b1;
    rst_n = 1'b1;
    tick(5);
    check("lat_edge5", 32'(sig_out), 32'd0);
    tick(1);
    check("lat_edge6", 32'(sig_out), 32'd1);
    check("lat_rise6", 32'(rise_pulse), 32'd1);
    tick(1);
    check("lat_rise7", 32'(rise_pulse), 32'd0);
    snapshot("first", 1);
    sig_in = 1'b0; tick(10);
    check("first_fall", 32'(sig_out), 32'd0);

    // 2. Glitch rejection and minimum accepted pulse.
    clear();
    n_rise = 0; n_fall = 0; n_high = 0;
    pulse(3, 12);
    check("glitch_rise", 32'(n_rise), 32'd0);
    check("glitch_high", 32'(n_high), 32'd0);
    n_rise = 0; n_fall = 0; n_high = 0;
    pulse(4, 12);
    check("min_rise", 32'(n_rise), 32'd1);
    check("min_fall", 32'(n_fall), 32'd1);
    check("min_high", 32'(n_high), 32'd4);
    snapshot("glitch", 1);

    // 3. Counting and snapshot.
    clear();
    repeat (10) pulse(8, 8);
    snapshot("ten", 10);
    snap_req = 1'b1; tick(4);
    check("hold_ack", 32'(snap_ack), 32'd1);
    check("hold_frozen", 32'(snap_count), 32'd10);
    snap_req = 1'b0; tick(1);

    // 4. Saturation and clear.
    repeat (7) pulse(8, 8);
    snapshot("sat", 15);
    check("sat_ovf", 32'(overflow), 32'd1);
    clear(); tick(1);
    check("clr_ovf", 32'(overflow), 32'd0);
    snapshot("clr", 0);

    // 5. Coincidences: clr against a rise, snapshot against a rise.
    repeat (3) pulse(8, 8);
    sig_in = 1'b1;
    wait_rise("clr_co");
    clear();
    sig_in = 1'b0; tick(10);
    snapshot("clr_co", 0);
    repeat (5) pulse(8, 8);
    sig_in = 1'b1;
    wait_rise("snap_co");
    snap_req = 1'b1; tick(1);
    check("snap_co_cnt", 32'(snap_count), 32'd5);
    snap_req = 1'b0; tick(2);
    snapshot("snap_after", 6);

    // 6. Asynchronous reset while holding a snapshot.
    snap_req = 1'b1; tick(1);
    check("pre_rst_ack", 32'(snap_ack), 32'd1);
    check("pre_rst_out", 32'(sig_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ack", 32'(snap_ack), 32'd0);
    check("arst_snap", 32'(snap_count), 32'd0);
    check("arst_out", 32'(sig_out), 32'd0);
    tick(1);
    rst_n = 1'b1;
    #1;
    check("post_rst_idle", 32'(snap_ack), 32'd0);
    tick(1);
    check("post_rst_ack", 32'(snap_ack), 32'd1);
    snap_req = 1'b0; sig_in = 1'b0; tick(12);

    // Randomized phase: mixed glitches, clean pulses, clears and snapshots.
    for (int i = 0; i < 400; i++) begin
      sig_in = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) snap_req = ~snap_req;
      tick($urandom_range(1, 12));
      clr = 1'b0;
    end
    sig_in = 1'b0; snap_req = 1'b0; tick(12);
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sig_edge_monitor.md
Name: sig_edge_monitor

Overview:
- Single-clock receive-side conditioner for a renamed fabric-level signal, e.g. a strobe or status line routed through the signal-rename layer into fab_clk logic.
- Synchronizes and debounces the raw input, then emits the clean level and one-cycle rise/fall pulses.
- Counts rising edges in a saturating counter.
- Software reads the counter through a req/ack snapshot handshake.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops (legal range 2-4)
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before sig_out changes (legal range 1-255)
CNT_WIDTH, 32, width of event counter and snapshot

Ports:
clk  input  1  fabric clock; all logic in this domain
rst_n  input  1  asynchronous active-low reset
sig_in  input  1  raw asynchronous input signal
sig_out  output  1  synchronized, debounced level
rise_pulse  output  1  one-cycle pulse on debounced 0->1
fall_pulse  output  1  one-cycle pulse on debounced 1->0
clr  input  1  synchronous clear of counter and overflow
snap_req  input  1  snapshot request, level
snap_ack  output  1  snapshot valid/acknowledge, level
snap_count  output  CNT_WIDTH  latched counter value
overflow  output  1  sticky: counter saturated

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is asynchronous and active-low, on rst_n.
  - rst_n low forces every flop to 0: synchronizer chain, debounce counter, sig_out, rise_pulse, fall_pulse, event counter, overflow, snap_count, snap_ack, FSM=IDLE.
  - Reset release is synchronous in effect; the first active edge after rst_n rises is normal operation.
- Synchronizer:
  - sig_in passes through SYNC_STAGES flops; the output is s_sync.
- Debounce:
  - An 8-bit stable counter increments while s_sync != sig_out.
  - The counter resets to 0 on any cycle where s_sync == sig_out.
  - When the counter reaches DEBOUNCE_CYCLES-1 and s_sync still differs, sig_out toggles on the next edge and the counter clears.
  - Latency from a clean sig_in step to the sig_out change: SYNC_STAGES + DEBOUNCE_CYCLES clk edges.
  - Glitches shorter than DEBOUNCE_CYCLES synchronized cycles never reach sig_out.
- Pulses:
  - rise_pulse / fall_pulse are registered and high for exactly the one cycle in which sig_out first shows its new value.
  - They are mutually exclusive.
- Event counter:
  - The counter increments on each rise_pulse.
  - At all-ones it holds; a further rise sets overflow=1 (sticky).
  - clr=1 sets counter=0 and overflow=0 on the next edge.
  - clr wins over a coincident rise: that edge is not counted.
- Snapshot FSM, states IDLE, HOLD:
  - IDLE: snap_ack=0. When snap_req=1, the next edge loads snap_count <= counter (pre-increment value if a rise coincides) and moves to HOLD.
  - HOLD: snap_ack=1 and snap_count frozen. When snap_req=0, the next edge clears snap_ack and returns to IDLE.
  - A new snapshot requires snap_req low for at least one cycle; holding snap_req high never re-samples.
  - clr does not alter snap_count or snap_ack.
- Reset mid-operation:
  - rst_n asserted at any time, including during HOLD or mid-debounce, immediately forces all outputs to 0.
  - Any pending debounce count is discarded.

Test Plan:
1. Reset/defaults: hold rst_n=0 with sig_in=1 -> all outputs 0. Release -> sig_out=1 after 2+4=6 edges, rise_pulse high exactly on cycle 6, count=1.
2. Glitch rejection: sig_in high for 3 cycles then low (defaults) -> sig_out stays 0, no pulses, count=0. A 4-cycle pulse -> sig_out high for 4 cycles, one rise_pulse and one fall_pulse.
3. Counting and snapshot: 10 clean pulses (each 8 cycles high/low), then snap_req=1 -> snap_ack=1 one edge later, snap_count=10. Deassert -> snap_ack=0 next edge.
4. Saturation: CNT_WIDTH=4, 17 pulses -> snap_count=15, overflow=1. Then clr -> next snapshot 0, overflow=0.
5. Coincidences: clr asserted on the cycle of rise_pulse -> count 0. A snapshot taken on a rise cycle with count=5 -> snap_count=5, later snapshot 6.
6. Reset in HOLD: snap_ack=1, then rst_n pulsed low mid-cycle -> snap_ack, snap_count, sig_out drop to 0 asynchronously, and the FSM restarts in IDLE.
